aes_decrypt_core: RTL and testbench

Iterative AES-128 inverse cipher (FIPS-197 §5.3), the decryption counterpart to the encryption datapath in the AES co-processor. It accepts a 128-bit cipher key and ciphertext with a start/done handshake. It derives the final round key on the fly by running the forward key schedule, then walks the schedule backwards one round per clock, so no round-key storage array is needed. It sits beside the encryption core behind the co-processor command interface.

---
 rtl/aes_decrypt_core.sv | 208 ++++++++++++++++++++
 tb/tb_aes_decrypt_core.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 inverse cipher: one round per clock, round keys recovered by running the key schedule backwards.
// Latency 21 clocks from the accepted start to the done pulse; start is ignored while busy, with no other backpressure.
module aes_decrypt_core (
   input  logic         clock,
   input  logic         reset,
   input  logic         start,
   input  logic [127:0] key_in,
   input  logic [127:0] cipher_text_in,
   output logic         busy,
   output logic         done,
   output logic [127:0] plain_text_out
);

   typedef enum logic [2:0] {IDLE, EXPAND, ADD10, ROUND, FINAL} fsm_t;

   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   localparam logic [0:255][7:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
   };

   function automatic logic [7:0] rcon(input logic [3:0] r);
      logic [7:0] v;
      case (r)
         4'd1:    v = 8'h01;
         4'd2:    v = 8'h02;
         4'd3:    v = 8'h04;
         4'd4:    v = 8'h08;
         4'd5:    v = 8'h10;
         4'd6:    v = 8'h20;
         4'd7:    v = 8'h40;
         4'd8:    v = 8'h80;
         4'd9:    v = 8'h1b;
         4'd10:   v = 8'h36;
         default: v = 8'h00;
      endcase
      return v;
   endfunction

   // SubWord(RotWord(w)) with the round constant folded into the top byte
   function automatic logic [31:0] sub_rot(input logic [31:0] w, input logic [7:0] rc);
      logic [31:0] v;
      v = {SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]], SBOX[w[31:24]]};
      return v ^ {rc, 24'h0};
   endfunction

   function automatic logic [127:0] fwd_key(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] n0, n1, n2, n3;
      n0 = k[127:96] ^ sub_rot(k[31:0], rc);
      n1 = k[95:64] ^ n0;
      n2 = k[63:32] ^ n1;
      n3 = k[31:0] ^ n2;
      return {n0, n1, n2, n3};
   endfunction

   function automatic logic [127:0] inv_key(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] n0, n1, n2, n3;
      n3 = k[31:0] ^ k[63:32];
      n2 = k[63:32] ^ k[95:64];
      n1 = k[95:64] ^ k[127:96];
      n0 = k[127:96] ^ sub_rot(n3, rc);
      return {n0, n1, n2, n3};
   endfunction

   // byte i sits at [127-8i -: 8]; row = i%4, column = i/4
   function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(r+4*c) -: 8] = INV_SBOX[s[127-8*(r+4*((c-r+4)%4)) -: 8]];
         end
      end
      return o;
   endfunction

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
      logic [7:0] a [4];
      logic [7:0] m9 [4], mb [4], md [4], me [4];
      logic [7:0] x2, x4, x8;
      for (int i = 0; i < 4; i++) begin
         a[i]  = col[31-8*i -: 8];
         x2    = xt(a[i]);
         x4    = xt(x2);
         x8    = xt(x4);
         m9[i] = x8 ^ a[i];
         mb[i] = x8 ^ x2 ^ a[i];
         md[i] = x8 ^ x4 ^ a[i];
         me[i] = x8 ^ x4 ^ x2;
      end
      return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
              m9[0] ^ me[1] ^ mb[2] ^ md[3],
              md[0] ^ m9[1] ^ me[2] ^ mb[3],
              mb[0] ^ md[1] ^ m9[2] ^ me[3]};
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      return {inv_mix_col(s[127:96]), inv_mix_col(s[95:64]),
              inv_mix_col(s[63:32]), inv_mix_col(s[31:0])};
   endfunction

   fsm_t         fsm, fsm_nxt;
   logic [127:0] state, state_nxt;
   logic [127:0] rk, rk_nxt;
   logic [127:0] ct, ct_nxt;
   logic [3:0]   count, count_nxt;
   logic [127:0] pt_nxt;
   logic         done_nxt;
   logic [3:0]   rc_idx;
   logic [127:0] rk_fwd, rk_inv, isr;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fsm            <= IDLE;
         state          <= '0;
         rk             <= '0;
         ct             <= '0;
         count          <= '0;
         plain_text_out <= '0;
         done           <= 1'b0;
      end else begin
         fsm            <= fsm_nxt;
         state          <= state_nxt;
         rk             <= rk_nxt;
         ct             <= ct_nxt;
         count          <= count_nxt;
         plain_text_out <= pt_nxt;
         done           <= done_nxt;
      end
   end

   always_comb begin
      fsm_nxt   = fsm;
      state_nxt = state;
      rk_nxt    = rk;
      ct_nxt    = ct;
      count_nxt = count;
      pt_nxt    = plain_text_out;
      done_nxt  = 1'b0;

      // one shared round-constant selector feeds both schedule directions
      case (fsm)
         EXPAND:  rc_idx = count + 4'd1;
         ADD10:   rc_idx = 4'd10;
         default: rc_idx = count;
      endcase
      rk_fwd = fwd_key(rk, rcon(rc_idx));
      rk_inv = inv_key(rk, rcon(rc_idx));
      isr    = inv_shift_sub(state);

      case (fsm)
         IDLE: begin
            if (start) begin
               rk_nxt    = key_in;
               ct_nxt    = cipher_text_in;
               count_nxt = 4'd0;
               fsm_nxt   = EXPAND;
            end
         end
         EXPAND: begin
            rk_nxt    = rk_fwd;
            count_nxt = count + 4'd1;
            if (count == 4'd9) fsm_nxt = ADD10;
         end
         ADD10: begin
            state_nxt = ct ^ rk;
            rk_nxt    = rk_inv;
            count_nxt = 4'd9;
            fsm_nxt   = ROUND;
         end
         ROUND: begin
            state_nxt = inv_mix_columns(isr ^ rk);
            rk_nxt    = rk_inv;
            count_nxt = count - 4'd1;
            if (count == 4'd1) fsm_nxt = FINAL;
         end
         FINAL: begin
            pt_nxt   = isr ^ rk;
            done_nxt = 1'b1;
            fsm_nxt  = IDLE;
         end
         default: fsm_nxt = IDLE;
      endcase
   end

   assign busy = (fsm != IDLE);

endmodule

// File: tb/tb_aes_decrypt_core.sv
// Directed and loopback bench for aes_decrypt_core; the S-box and the forward cipher
// used for loopback are derived here from GF(2^8) arithmetic.
module tb_aes_decrypt_core;

   logic         clock;
   logic         reset;
   logic         start;
   logic [127:0] key_in;
   logic [127:0] cipher_text_in;
   logic         busy;
   logic         done;
   logic [127:0] plain_text_out;

   aes_decrypt_core dut (
      .clock          (clock),
      .reset          (reset),
      .start          (start),
      .key_in         (key_in),
      .cipher_text_in (cipher_text_in),
      .busy           (busy),
      .done           (done),
      .plain_text_out (plain_text_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      string        name;
      logic [127:0] key;
      logic [127:0] ct;
      logic [127:0] pt;
      logic [127:0] rk10;
   } vec_t;

   vec_t       vecs [3];
   int         tests = 0;
   int         fails = 0;
   logic [7:0] sb [256];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa, bb;
      p = 8'h00; aa = a; bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
         bb = bb >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
      logic [7:0] r;
      r = (b << k) | (b >> (8 - k));
      return r;
   endfunction

   function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   a0, a1, a2, a3, rc;
      logic [127:0] rk, o;
      logic [31:0]  w0, w1, w2, w3, tmp;
      rk = key; rc = 8'h01;
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ key[127-8*i -: 8];
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
         for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++) s[w+4*c] = t[w+4*((c+w)%4)];
         if (r < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
               s[4*c+1] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
               s[4*c+2] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
               s[4*c+3] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
            end
         end
         w0 = rk[127:96]; w1 = rk[95:64]; w2 = rk[63:32]; w3 = rk[31:0];
         tmp = {sb[w3[23:16]] ^ rc, sb[w3[15:8]], sb[w3[7:0]], sb[w3[31:24]]};
         w0 = w0 ^ tmp; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
         rk = {w0, w1, w2, w3};
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[127-8*i -: 8];
         rc = gmul(rc, 8'h02);
      end
      o = '0;
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
      return o;
   endfunction

   // Drive start with data so that the next rising edge (E0) samples it.
   task automatic issue(input logic [127:0] k, input logic [127:0] c);
      start = 1'b1; key_in = k; cipher_text_in = c;
      @(posedge clock); #1;
      start = 1'b0; key_in = '0; cipher_text_in = '0;
   endtask

   // Counts edges after E0 until done; checks busy and output hold on the way.
   task automatic wait_done(input bit inject, output int lat, output logic [127:0] rk_e10);
      logic [127:0] pt_before;
      bit ok_busy, ok_hold;
      pt_before = plain_text_out;
      ok_busy = 1'b1; ok_hold = 1'b1; lat = 0; rk_e10 = '0;
      for (int n = 1; n <= 40 && lat == 0; n++) begin
         @(posedge clock); #1;
         start = 1'b0;
         if (n == 10) rk_e10 = dut.rk;
         if (done) begin
            lat = n;
            if (busy) ok_busy = 1'b0;
         end else begin
            if (!busy) ok_busy = 1'b0;
            if (plain_text_out !== pt_before) ok_hold = 1'b0;
            if (inject && (n % 4 == 1)) begin
               start = 1'b1;
               key_in = {$urandom, $urandom, $urandom, $urandom};
               cipher_text_in = {$urandom, $urandom, $urandom, $urandom};
            end
         end
      end
      check("busy_profile", 128'(ok_busy), 128'd1);
      check("pt_hold_until_done", 128'(ok_hold), 128'd1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int           lat, pulses;
      logic [127:0] rk_probe, k, p, c;
      logic [7:0]   inv, b;

      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         b = inv;
         sb[x] = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
      end

      vecs[0] = '{"fips_c1", 128'h000102030405060708090a0b0c0d0e0f,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                  128'h00112233445566778899aabbccddeeff,
                  128'h13111d7fe3944a17f307a78b4d2b30c5};
      vecs[1] = '{"fips_appb", 128'h2b7e151628aed2a6abf7158809cf4f3c,
                  128'h3925841d02dc09fbdc118597196a0b32,
                  128'h3243f6a8885a308d313198a2e0370734,
                  128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
      vecs[2] = '{"zero_key", 128'h0,
                  128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
                  128'h0,
                  128'hb4ef5bcb3e92e21123e951cf6f8f188e};

      reset = 1'b0; start = 1'b0; key_in = '0; cipher_text_in = '0;
      #12;
      check("reset_busy", 128'(busy), 128'd0);
      check("reset_done", 128'(done), 128'd0);
      check("reset_pt", plain_text_out, 128'd0);
      @(negedge clock); reset = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clock);
         issue(vecs[i].key, vecs[i].ct);
         wait_done(1'b0, lat, rk_probe);
         check({vecs[i].name, "_latency"}, 128'(lat), 128'd21);
         check({vecs[i].name, "_pt"}, plain_text_out, vecs[i].pt);
         check({vecs[i].name, "_rk10"}, rk_probe, vecs[i].rk10);
         @(posedge clock); #1;
         check({vecs[i].name, "_done_width"}, 128'(done), 128'd0);
      end

      // back-to-back: second start in the done cycle
      @(negedge clock);
      issue(vecs[0].key, vecs[0].ct);
      wait_done(1'b0, lat, rk_probe);
      check("b2b_first_latency", 128'(lat), 128'd21);
      check("b2b_first_pt", plain_text_out, vecs[0].pt);
      issue(vecs[1].key, vecs[1].ct);
      check("b2b_done_width", 128'(done), 128'd0);
      wait_done(1'b0, lat, rk_probe);
      check("b2b_second_latency", 128'(lat), 128'd21);
      check("b2b_second_pt", plain_text_out, vecs[1].pt);
      pulses = 0;
      for (int n = 0; n < 30; n++) begin
         @(posedge clock); #1;
         if (done) pulses++;
      end
      check("b2b_extra_done", 128'(pulses), 128'd0);

      // start pulses with other data while busy must be ignored
      @(negedge clock);
      issue(vecs[0].key, vecs[0].ct);
      wait_done(1'b1, lat, rk_probe);
      check("busy_ignore_latency", 128'(lat), 128'd21);
      check("busy_ignore_pt", plain_text_out, vecs[0].pt);
      check("busy_ignore_rk10", rk_probe, vecs[0].rk10);

      // asynchronous reset in the middle of an operation
      @(negedge clock);
      issue(vecs[1].key, vecs[1].ct);
      repeat (14) @(posedge clock);
      #2 reset = 1'b0;
      #1;
      check("midreset_busy", 128'(busy), 128'd0);
      check("midreset_done", 128'(done), 128'd0);
      check("midreset_pt", plain_text_out, 128'd0);
      pulses = 0;
      for (int n = 0; n < 25; n++) begin
         @(posedge clock); #1;
         if (done) pulses++;
         if (n == 3) reset = 1'b1;
      end
      check("midreset_no_done", 128'(pulses), 128'd0);
      @(negedge clock);
      issue(vecs[0].key, vecs[0].ct);
      wait_done(1'b0, lat, rk_probe);
      check("post_reset_latency", 128'(lat), 128'd21);
      check("post_reset_pt", plain_text_out, vecs[0].pt);

      // random loopback against the bench's forward cipher
      for (int n = 0; n < 1000; n++) begin
         k = {$urandom, $urandom, $urandom, $urandom};
         p = {$urandom, $urandom, $urandom, $urandom};
         c = aes_enc(k, p);
         @(negedge clock);
         issue(k, c);
         wait_done(1'b0, lat, rk_probe);
         check("loop_latency", 128'(lat), 128'd21);
         check("loop_pt", plain_text_out, p);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
